// File: rtl/garbage_receive_pkg.sv
// Shared sizes, limits and FSM encodings for the garbage receiver.
// Board geometry mirrors the legacy global defines.
package garbage_receive_pkg;

  localparam int BLOCKS_ROW = 10;
  localparam int BLOCKS_COL = 20;
  localparam int BITS_Y_POS = 5;

  localparam int GARBAGE_MAX_PENDING = 20;
  localparam int GARBAGE_MAX_BURST   = 4;

  typedef enum logic [1:0] {
    GR_IDLE   = 2'd0,
    GR_SHIFT  = 2'd1,
    GR_COMMIT = 2'd2
  } gr_state_t;

endpackage

// File: rtl/garbage_hole_gen.sv
// Hole column selector: round-robin by default,
// LFSR-based when GARBAGE_RANDOM_HOLE_EN is defined.
module garbage_hole_gen #(
  parameter int ROW_W  = 10,
  parameter int HOLE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              state_rst,
  input  logic              advance,
  output logic [HOLE_W-1:0] hole
);

`ifdef GARBAGE_RANDOM_HOLE_EN
  logic [7:0] lfsr;
  logic [4:0] low;
  logic       unused_advance;

  assign unused_advance = advance;

  // x^8+x^6+x^5+x^4+1, free-running even while paused
  always_ff @(posedge clk) begin
    if (rst || state_rst) begin
      lfsr <= 8'h01;
    end else begin
      lfsr <= {lfsr[6:0],
               lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign low  = {1'b0, lfsr[3:0]};
  assign hole = HOLE_W'((low >= 5'(ROW_W))
                ? low - 5'(ROW_W) : low);
`else
  always_ff @(posedge clk) begin
    if (rst || state_rst) begin
      hole <= '0;
    end else if (advance) begin
      hole <= (hole == HOLE_W'(ROW_W - 1))
              ? '0 : hole + HOLE_W'(1);
    end
  end
`endif

endmodule

// File: rtl/garbage_receive.sv
// Garbage line receiver: pending counter, burst insertion, board commit.
// Optional GARBAGE_RANDOM_HOLE_EN selects LFSR hole placement.
module garbage_receive
  import garbage_receive_pkg::*;
#(
  parameter int ROW_W       = BLOCKS_ROW,
  parameter int COL_H       = BLOCKS_COL,
  parameter int PEND_W      = 6,
  parameter int MAX_PENDING = GARBAGE_MAX_PENDING,
  parameter int MAX_BURST   = GARBAGE_MAX_BURST
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   state_rst,
  input  logic                   pause,
  input  logic                   recv,
  input  logic                   cancel,
  input  logic                   insert_req,
  input  logic [ROW_W*COL_H-1:0] game_board,
  output logic [ROW_W*COL_H-1:0] board_out,
  output logic                   board_we,
  output logic                   busy,
  output logic [PEND_W-1:0]      pending,
  output logic [5:0]             lines_received,
  output logic                   topout
);

  localparam int BW     = ROW_W * COL_H;
  localparam int HOLE_W = (ROW_W > 1) ? $clog2(ROW_W) : 1;
  localparam int CNT_W  = $clog2(MAX_BURST + 1);

  localparam logic [PEND_W-1:0] MAX_P = PEND_W'(MAX_PENDING);
  localparam logic [PEND_W-1:0] BST_P = PEND_W'(MAX_BURST);

  gr_state_t         state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [BW-1:0]     shadow, shifted;
  logic [HOLE_W-1:0] hole, hole_q;
  logic [ROW_W-1:0]  fill_row;
  logic [PEND_W-1:0] take, pend_base, pend_nxt;
  logic              clr, accept, shift_en;

  assign clr      = rst | state_rst;
  assign accept   = (state == GR_IDLE) && insert_req &&
                    (pending != '0) && !pause;
  assign shift_en = (state == GR_SHIFT) && !pause;
  assign take     = (pending > BST_P) ? BST_P : pending;

  // Row 0 is the LSB slice, so shifting up drops the low row
  assign fill_row = ~(ROW_W'(1) << hole_q);
  assign shifted  = {fill_row, shadow[BW-1:ROW_W]};

  assign busy     = (state != GR_IDLE);
  assign board_we = (state == GR_COMMIT) && !pause;

  garbage_hole_gen #(
    .ROW_W  (ROW_W),
    .HOLE_W (HOLE_W)
  ) u_hole (
    .clk       (clk),
    .rst       (rst),
    .state_rst (state_rst),
    .advance   (accept),
    .hole      (hole)
  );

  always_comb begin
    state_nxt = state;
    if (!pause) begin
      unique case (state)
        GR_IDLE:   if (accept) state_nxt = GR_SHIFT;
        GR_SHIFT:  if (cnt == CNT_W'(1)) state_nxt = GR_COMMIT;
        GR_COMMIT: state_nxt = GR_IDLE;
        default:   state_nxt = GR_IDLE;
      endcase
    end
  end

  always_comb begin
    pend_base = accept ? pending - take : pending;
    pend_nxt  = pend_base;
    if (!pause) begin
      if (recv && !cancel) begin
        pend_nxt = (pend_base >= MAX_P)
                   ? MAX_P : pend_base + PEND_W'(1);
      end else if (cancel && !recv) begin
        pend_nxt = (pend_base == '0)
                   ? '0 : pend_base - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state          <= GR_IDLE;
      cnt            <= '0;
      shadow         <= '0;
      hole_q         <= '0;
      pending        <= '0;
      lines_received <= '0;
      topout         <= 1'b0;
      board_out      <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pend_nxt;
      if (accept) begin
        shadow <= game_board;
        cnt    <= CNT_W'(take);
        hole_q <= hole;
      end
      if (shift_en) begin
        shadow         <= shifted;
        cnt            <= cnt - CNT_W'(1);
        lines_received <= lines_received + 6'd1;
        if (shadow[ROW_W-1:0] != '0) topout <= 1'b1;
        // Publish on the last shift so data is valid with board_we
        if (cnt == CNT_W'(1)) board_out <= shifted;
      end
    end
  end

endmodule

// File: tb/tb_garbage_receive.sv
// Directed bench for garbage_receive (default round-robin hole build).
// Inputs change 1ns after posedge; outputs are sampled there too.
module tb_garbage_receive;

  localparam int BW = 200;

  logic          clk = 1'b0;
  logic          rst, state_rst, pause;
  logic          recv, cancel, insert_req;
  logic [BW-1:0] game_board;
  logic [BW-1:0] board_out;
  logic          board_we, busy, topout;
  logic [5:0]    pending, lines_received;

  int checks = 0;
  int errors = 0;

  garbage_receive dut (
    .clk            (clk),
    .rst            (rst),
    .state_rst      (state_rst),
    .pause          (pause),
    .recv           (recv),
    .cancel         (cancel),
    .insert_req     (insert_req),
    .game_board     (game_board),
    .board_out      (board_out),
    .board_we       (board_we),
    .busy           (busy),
    .pending        (pending),
    .lines_received (lines_received),
    .topout         (topout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [BW-1:0] got,
                       input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_recv(input int n);
    repeat (n) begin
      recv = 1'b1;
      tick();
      recv = 1'b0;
    end
  endtask

  task automatic do_insert();
    insert_req = 1'b1;
    tick();
    insert_req = 1'b0;
  endtask

  task automatic wait_we(output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (!board_we && k < 30);
  endtask

  function automatic logic [BW-1:0] bottom(input int rows,
                                           input logic [9:0] row);
    logic [BW-1:0] b;
    b = '0;
    for (int i = 0; i < rows; i++) b[(19-i)*10 +: 10] = row;
    return b;
  endfunction

  int   k, k2;
  logic seen_we;

  initial begin
    rst = 1'b1; state_rst = 1'b0; pause = 1'b0;
    recv = 1'b0; cancel = 1'b0; insert_req = 1'b0;
    game_board = '0;
    tick(); tick();
    rst = 1'b0;

    check("rst_board", board_out, '0);
    check("rst_we", BW'(board_we), '0);
    check("rst_busy", BW'(busy), '0);
    check("rst_pend", BW'(pending), '0);
    check("rst_lines", BW'(lines_received), '0);
    check("rst_topout", BW'(topout), '0);

    // three lines into an empty board, hole 0
    pulse_recv(3);
    check("t1_pend3", BW'(pending), BW'(3));
    do_insert();
    check("t1_busy", BW'(busy), BW'(1));
    check("t1_pend0", BW'(pending), '0);
    wait_we(k);
    check("t1_lat", BW'(k), BW'(3));
    check("t1_board", board_out, bottom(3, 10'h3FE));
    check("t1_lines", BW'(lines_received), BW'(3));
    tick();
    check("t1_we_off", BW'(board_we), '0);
    check("t1_idle", BW'(busy), '0);
    check("t1_hold", board_out, bottom(3, 10'h3FE));

    // six pending split into bursts of 4 and 2
    pulse_recv(6);
    check("t2_pend6", BW'(pending), BW'(6));
    do_insert();
    check("t2_pend2", BW'(pending), BW'(2));
    wait_we(k);
    check("t2_lat4", BW'(k), BW'(4));
    check("t2_board4", board_out, bottom(4, 10'h3FD));
    tick();
    do_insert();
    check("t2_pend0", BW'(pending), '0);
    wait_we(k);
    check("t2_lat2", BW'(k), BW'(2));
    check("t2_board2", board_out, bottom(2, 10'h3FB));
    check("t2_lines", BW'(lines_received), BW'(9));
    tick();

    // pending arithmetic
    pulse_recv(1);
    recv = 1'b1; cancel = 1'b1;
    tick();
    recv = 1'b0; cancel = 1'b0;
    check("t3_both", BW'(pending), BW'(1));
    cancel = 1'b1;
    tick(); tick();
    cancel = 1'b0;
    check("t3_floor", BW'(pending), '0);
    pulse_recv(25);
    check("t3_sat", BW'(pending), BW'(20));
    state_rst = 1'b1;
    tick();
    state_rst = 1'b0;
    check("t3_srst_pend", BW'(pending), '0);
    check("t3_srst_lines", BW'(lines_received), '0);
    check("t3_srst_board", board_out, '0);

    // topout: row 0 occupied, row 5 carries a marker
    pulse_recv(1);
    game_board = '0;
    game_board[0] = 1'b1;
    game_board[50 +: 10] = 10'h2AA;
    do_insert();
    game_board = '0;
    check("t4_pre", BW'(topout), '0);
    wait_we(k);
    check("t4_lat", BW'(k), BW'(1));
    check("t4_topout", BW'(topout), BW'(1));
    check("t4_board", board_out,
          (BW'(10'h2AA) << 40) | bottom(1, 10'h3FE));
    tick(); tick(); tick();
    check("t4_sticky", BW'(topout), BW'(1));
    state_rst = 1'b1;
    tick();
    state_rst = 1'b0;
    check("t4_clr", BW'(topout), '0);

    // load a board, then abort a 4-row burst at t+2
    pulse_recv(1);
    do_insert();
    wait_we(k);
    tick();
    check("t5_pre", board_out, bottom(1, 10'h3FE));
    pulse_recv(4);
    seen_we = 1'b0;
    do_insert();
    seen_we |= board_we;
    tick();
    seen_we |= board_we;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen_we |= board_we;
    check("t5_board", board_out, '0);
    check("t5_busy", BW'(busy), '0);
    check("t5_pend", BW'(pending), '0);
    check("t5_lines", BW'(lines_received), '0);
    repeat (6) begin
      tick();
      seen_we |= board_we;
    end
    check("t5_no_we", BW'(seen_we), '0);

    // pause for five cycles mid-burst
    pulse_recv(2);
    do_insert();
    seen_we = 1'b0;
    k = 0;
    pause = 1'b1; recv = 1'b1;
    repeat (5) begin
      tick();
      k++;
      seen_we |= board_we;
    end
    pause = 1'b0; recv = 1'b0;
    check("t6_pend", BW'(pending), '0);
    check("t6_no_we", BW'(seen_we), '0);
    wait_we(k2);
    check("t6_lat", BW'(k + k2), BW'(7));
    check("t6_board", board_out, bottom(2, 10'h3FE));
    check("t6_lines", BW'(lines_received), BW'(2));
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/garbage_receive.md
# garbage_receive

Receiving end of the attack-line link: counts garbage lines sent by the opponent's row-clear logic, cancels them against local clears, and, when the current piece locks, inserts up to a burst of garbage rows at the bottom of the local board. Rows are shifted up one per cycle in a shadow copy. Each inserted row is solid except for a single hole column. The finished board is handed back to the board owner with a one-cycle write strobe.

## Interface
- `ROW_W`, default 10: cells per row (`BLOCKS_ROW`).
- `COL_H`, default 20: rows per board (`BLOCKS_COL`).
- `PEND_W`, default 6: width of the pending counter.
- `MAX_PENDING`, default 20: saturation limit for pending lines.
- `MAX_BURST`, default 4: maximum rows inserted per lock.
- `clk  in  1`: single clock.
- `rst  in  1`: reset, synchronous, active-high.
- `state_rst  in  1`: round restart. Same effect as `rst`.
- `pause  in  1`: freezes the FSM. `recv` and `cancel` are ignored while high.
- `recv  in  1`: one-cycle pulse = one incoming garbage line (the opponent's `send`).
- `cancel  in  1`: one-cycle pulse = one local line sent, offsets one pending line.
- `insert_req  in  1`: pulse on piece lock.
- `game_board  in  ROW_W*COL_H`: current board. Row r is `[r*ROW_W +: ROW_W]`, row 0 is the top.
- `board_out  out  ROW_W*COL_H`: board after insertion.
- `board_we  out  1`: one-cycle strobe. The owner loads `board_out` on this cycle.
- `busy  out  1`: insertion in progress.
- `pending  out  PEND_W`: garbage lines waiting.
- `lines_received  out  6`: total lines inserted this round. Wraps at 64.
- `topout  out  1`: sticky. Set when a non-empty row is pushed off the top.

## Operation
- FSM states:
  - IDLE → SHIFT: on `insert_req` with `pending`≠0, `!pause`.
  - SHIFT → COMMIT: when the burst counter reaches 0.
  - COMMIT → IDLE: unconditional.
- Accept, in IDLE:
  - shadow ← `game_board`.
  - n = min(`pending`, `MAX_BURST`); burst counter ← n; `pending` ← `pending` − n.
  - Hole column is latched once per burst.
- `insert_req` with `pending`=0, or outside IDLE, is ignored; nothing is queued.
- Each SHIFT cycle:
  - Shadow row r ← row r+1 for r < COL_H−1.
  - Bottom row ← all ones except the hole bit.
  - If shadow row 0 was non-zero before the shift, set `topout`.
  - Burst counter decrements; `lines_received` increments.
- COMMIT: `board_out` ← shadow and `board_we`=1 for exactly one cycle. `board_out` holds its value afterwards.
- Pending arithmetic, applied every unpaused cycle, including during SHIFT and COMMIT:
  - +1 on `recv`, −1 on `cancel` (floor 0), saturating at `MAX_PENDING`.
  - `recv` and `cancel` in the same cycle leave it unchanged.
  - On the accept cycle, the subtraction of n combines with that cycle's `recv`/`cancel`.
- `rst`/`state_rst` mid-burst: the burst is aborted, no `board_we`, the shadow is discarded, and all outputs return to reset values.
- Reset values: `board_out`=0, `board_we`=0, `busy`=0, `pending`=0, `lines_received`=0, `topout`=0, state IDLE.

## Timing
- Accept at cycle t.
- Shifts occur on cycles t+1 … t+n.
- `board_we` is asserted at t+n+1.
- `busy` is high for t+1 … t+n+1.
- Back-to-back: the next accept is possible at t+n+2.
- Pause freezes state, the burst counter and the shadow. Elapsed cycles add to the latency.
- `board_we` is never asserted while `pause` is high.
- `game_board` is sampled only on the accept cycle.

## Configuration
- `GARBAGE_RANDOM_HOLE_EN` defined: hole = 8-bit free-running LFSR (x^8+x^6+x^5+x^4+1, seed 8'h01 on reset).
  - Take the low 4 bits; if the value ≥ `ROW_W`, subtract `ROW_W`.
  - The LFSR advances every cycle, including during pause.
- Not defined: hole = round-robin column, starting at 0 after reset. It advances by 1 per accepted burst and wraps at `ROW_W`−1 → 0.

## Structure
- `global.v` holds:
  - Existing: `BLOCKS_ROW`, `BLOCKS_COL`, `BITS_Y_POS`.
  - New: `GARBAGE_MAX_PENDING`, `GARBAGE_MAX_BURST`, and the state encodings `GR_IDLE`=2'd0, `GR_SHIFT`=2'd1, `GR_COMMIT`=2'd2.
- One sub-module, `garbage_hole_gen`: LFSR / round-robin hole selection. It takes `clk`, `rst`, `state_rst` and an advance strobe, and outputs the hole index.

## Test plan
- Send 3 `recv` pulses, then `insert_req` on an empty board → 3 shift cycles, then `board_we` at t+4; bottom 3 rows = 10'h3FF minus the same hole bit; `pending`=0; `lines_received`=3.
- `pending`=6 with `MAX_BURST`=4, then `insert_req` → 4 rows inserted, `pending`=2; second `insert_req` → 2 rows inserted, `pending`=0.
- `recv`+`cancel` in the same cycle → `pending` unchanged; `cancel` at `pending`=0 → stays 0; 25 `recv` pulses → `pending`=20.
- Board with row 0 non-zero, `pending`=1, `insert_req` → `topout`=1 and stays 1 until `state_rst`.
- `rst` asserted at t+2 of a 4-row burst → `board_we` never pulses; all outputs 0 the next cycle.
- `pause` held 5 cycles mid-burst → `board_we` is delayed by exactly 5 cycles; `recv` during the pause does not change `pending`.
